// File: rtl/pc_redirect_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit_if
// Description : Bundle between ID-stage branch/jump decode and the fetch PC
//               stage: redirect request inputs and PC/nPC/flush outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_redirect_unit_if #(
    parameter int ADDR_W = 32
);
    logic              pc_ld;
    logic              ID_branch_instr;
    logic              branch_out;
    logic              jump;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
    logic              if_id_flush;
    logic              redirect_pending;

    // Upstream side: stall control and ID-stage decisions.
    modport master (
        output pc_ld, ID_branch_instr, branch_out, jump, target,
        input  pc, npc, if_id_flush, redirect_pending
    );

    // PC stage side.
    modport slave (
        input  pc_ld, ID_branch_instr, branch_out, jump, target,
        output pc, npc, if_id_flush, redirect_pending
    );
endinterface
`default_nettype wire

// File: rtl/pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : pc_redirect_unit
// Description : Fetch PC/nPC stage with stall-time redirect buffering and
//               IF/ID squash. Build macro DELAY_SLOT_EN selects MIPS-style
//               delay-slot redirects (no squash).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_redirect_unit #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  wire logic         clk,
    input  wire logic         reset,
    pc_redirect_unit_if.slave bus
);
    localparam logic [0:0]        c_run     = 1'b0;
    localparam logic [0:0]        c_hold    = 1'b1;
    localparam logic [ADDR_W-1:0] c_pc_step = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] c_tgt_msk = ~ADDR_W'(3);

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [ADDR_W-1:0] pend_tgt_q, pend_tgt_d;

    logic              w_redirect_req;
    logic [ADDR_W-1:0] w_tgt;
    logic              w_apply;
    logic [ADDR_W-1:0] w_apply_tgt;

    assign w_redirect_req = (bus.ID_branch_instr & bus.branch_out) | bus.jump;
    assign w_tgt          = bus.target & c_tgt_msk;

    // State register and datapath flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= c_run;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC + c_pc_step;
            pend_tgt_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            npc_q      <= npc_d;
            pend_tgt_q <= pend_tgt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            c_run:   if (!bus.pc_ld && w_redirect_req) state_d = c_hold;
            c_hold:  if (bus.pc_ld) state_d = c_run;
            default: state_d = c_run;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        npc_d       = npc_q;
        pend_tgt_d  = pend_tgt_q;
        w_apply     = 1'b0;
        w_apply_tgt = w_tgt;
        case (state_q)
            c_run: begin
                if (bus.pc_ld) begin
                    if (w_redirect_req) begin
                        w_apply = 1'b1;
                    end else begin
                        pc_d  = npc_q;
                        npc_d = npc_q + c_pc_step;
                    end
                end else if (w_redirect_req) begin
                    pend_tgt_d = w_tgt;
                end
            end
            c_hold: begin
                // The held ID instruction re-presents its request on release; ignore it.
                if (bus.pc_ld) begin
                    w_apply     = 1'b1;
                    w_apply_tgt = pend_tgt_q;
                end else if (w_redirect_req) begin
                    pend_tgt_d = w_tgt;
                end
            end
            default: ;
        endcase

        if (w_apply) begin
`ifdef DELAY_SLOT_EN
            pc_d  = npc_q;
            npc_d = w_apply_tgt;
`else
            pc_d  = w_apply_tgt;
            npc_d = w_apply_tgt + c_pc_step;
`endif
        end
    end

    assign bus.pc               = pc_q;
    assign bus.npc              = npc_q;
    assign bus.redirect_pending = (state_q == c_hold);
`ifdef DELAY_SLOT_EN
    assign bus.if_id_flush      = 1'b0;
`else
    assign bus.if_id_flush      = w_apply & ~reset;
`endif
endmodule
`default_nettype wire

// File: tb/tb_pc_redirect_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_redirect_unit
// Description : Directed vector table, wrap sequence and randomized run
//               against a behavioural PC model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_redirect_unit;
`ifdef DELAY_SLOT_EN
    localparam bit DS = 1'b1;
`else
    localparam bit DS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    pc_redirect_unit_if #(.ADDR_W(32)) dut_if ();

    pc_redirect_unit #(.ADDR_W(32), .RESET_PC(32'h0)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        ld;
        logic        bi;
        logic        bo;
        logic        j;
        logic [31:0] tgt;
        logic        ef;
        logic [31:0] epc;
        logic [31:0] enpc;
        logic        epend;
    } vec_t;

    vec_t vecs[15];

    // Behavioural model state
    logic [31:0] m_pc, m_npc, m_ptgt;
    logic        m_pend;

    function automatic vec_t mk(input logic rst, ld, bi, bo, j, input logic [31:0] tgt,
                                input logic ef, input logic [31:0] epc, enpc, input logic epend);
        vec_t v;
        v.rst = rst; v.ld = ld; v.bi = bi; v.bo = bo; v.j = j; v.tgt = tgt;
        v.ef = ef; v.epc = epc; v.enpc = enpc; v.epend = epend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, ld, bi, bo, j, input logic [31:0] tgt);
        @(negedge clk);
        reset                  = rst;
        dut_if.pc_ld           = ld;
        dut_if.ID_branch_instr = bi;
        dut_if.branch_out      = bo;
        dut_if.jump            = j;
        dut_if.target          = tgt;
        #1;
    endtask

    task automatic after_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic model_apply(input logic [31:0] t);
        if (DS) begin
            m_pc  = m_npc;
            m_npc = t;
        end else begin
            m_pc  = t;
            m_npc = t + 32'd4;
        end
    endtask

    task automatic model_step(input logic rst, ld, bi, bo, j, input logic [31:0] tgt);
        logic        req;
        logic [31:0] t;
        req = (bi & bo) | j;
        t   = {tgt[31:2], 2'b00};
        if (rst) begin
            m_pc = 32'h0; m_npc = 32'h4; m_pend = 1'b0;
        end else if (ld) begin
            if (m_pend) begin
                model_apply(m_ptgt);
                m_pend = 1'b0;
            end else if (req) begin
                model_apply(t);
            end else begin
                m_pc  = m_npc;
                m_npc = m_npc + 32'd4;
            end
        end else if (req) begin
            m_pend = 1'b1;
            m_ptgt = t;
        end
    endtask

    initial begin
        reset = 1'b1;
        dut_if.pc_ld = 1'b0; dut_if.ID_branch_instr = 1'b0; dut_if.branch_out = 1'b0;
        dut_if.jump = 1'b0; dut_if.target = '0;

        //             rst ld bi bo j  tgt           flush     pc                         npc                        pend
        vecs[0]  = mk(1, 0, 0, 0, 0, 32'h0,   0,        32'h0,                     32'h4,                     0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 32'h0,   0,        32'h0,                     32'h4,                     0);
        vecs[2]  = mk(0, 1, 0, 0, 0, 32'h0,   0,        32'h4,                     32'h8,                     0);
        vecs[3]  = mk(0, 1, 0, 0, 0, 32'h0,   0,        32'h8,                     32'hC,                     0);
        vecs[4]  = mk(0, 1, 1, 1, 0, 32'h40,  !DS,      DS ? 32'hC  : 32'h40,      DS ? 32'h40 : 32'h44,      0);
        vecs[5]  = mk(0, 1, 0, 0, 0, 32'h0,   0,        DS ? 32'h40 : 32'h44,      DS ? 32'h44 : 32'h48,      0);
        vecs[6]  = mk(0, 0, 0, 0, 1, 32'h80,  0,        DS ? 32'h40 : 32'h44,      DS ? 32'h44 : 32'h48,      1);
        vecs[7]  = mk(0, 0, 0, 0, 1, 32'h90,  0,        DS ? 32'h40 : 32'h44,      DS ? 32'h44 : 32'h48,      1);
        vecs[8]  = mk(0, 1, 0, 0, 1, 32'hA0,  !DS,      DS ? 32'h44 : 32'h90,      DS ? 32'h90 : 32'h94,      0);
        vecs[9]  = mk(0, 1, 0, 0, 0, 32'h0,   0,        DS ? 32'h90 : 32'h94,      DS ? 32'h94 : 32'h98,      0);
        vecs[10] = mk(0, 1, 0, 1, 0, 32'h200, 0,        DS ? 32'h94 : 32'h98,      DS ? 32'h98 : 32'h9C,      0);
        vecs[11] = mk(0, 0, 0, 0, 1, 32'h100, 0,        DS ? 32'h94 : 32'h98,      DS ? 32'h98 : 32'h9C,      1);
        vecs[12] = mk(1, 1, 0, 0, 1, 32'h100, 0,        32'h0,                     32'h4,                     0);
        vecs[13] = mk(0, 1, 0, 0, 0, 32'h0,   0,        32'h4,                     32'h8,                     0);
        vecs[14] = mk(0, 1, 1, 1, 0, 32'h43,  !DS,      DS ? 32'h8  : 32'h40,      DS ? 32'h40 : 32'h44,      0);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].ld, vecs[i].bi, vecs[i].bo, vecs[i].j, vecs[i].tgt);
            check($sformatf("vec%0d flush", i), {31'b0, dut_if.if_id_flush}, {31'b0, vecs[i].ef});
            after_edge();
            check($sformatf("vec%0d pc", i),   dut_if.pc,  vecs[i].epc);
            check($sformatf("vec%0d npc", i),  dut_if.npc, vecs[i].enpc);
            check($sformatf("vec%0d pend", i), {31'b0, dut_if.redirect_pending}, {31'b0, vecs[i].epend});
        end

        // Wrap-around: steer npc to FFFFFFFC, then advance once.
        drive(0, 1, 0, 0, 1, 32'hFFFF_FFF8);
        after_edge();
        check("wrap jump npc", dut_if.npc, DS ? 32'hFFFF_FFF8 : 32'hFFFF_FFFC);
        if (DS) begin
            drive(0, 1, 0, 0, 0, 32'h0);
            after_edge();
        end
        check("wrap pre npc", dut_if.npc, 32'hFFFF_FFFC);
        drive(0, 1, 0, 0, 0, 32'h0);
        after_edge();
        check("wrap pc", dut_if.pc, 32'hFFFF_FFFC);
        check("wrap npc", dut_if.npc, 32'h0000_0000);

        // Randomized run against the model, synchronised by a reset cycle.
        drive(1, 0, 0, 0, 0, 32'h0);
        after_edge();
        model_step(1, 0, 0, 0, 0, 32'h0);
        for (int n = 0; n < 400; n++) begin
            logic rst, ld, bi, bo, j, ef;
            logic [31:0] tgt;
            rst = ($urandom_range(0, 39) == 0);
            ld  = ($urandom_range(0, 2) != 0);
            bi  = $urandom_range(0, 1);
            bo  = $urandom_range(0, 1);
            j   = ($urandom_range(0, 4) == 0);
            tgt = $urandom;
            ef  = !rst && ld && !DS && (m_pend || (bi & bo) || j);
            drive(rst, ld, bi, bo, j, tgt);
            check($sformatf("rnd%0d flush", n), {31'b0, dut_if.if_id_flush}, {31'b0, ef});
            after_edge();
            model_step(rst, ld, bi, bo, j, tgt);
            check($sformatf("rnd%0d pc", n),   dut_if.pc,  m_pc);
            check($sformatf("rnd%0d npc", n),  dut_if.npc, m_npc);
            check($sformatf("rnd%0d pend", n), {31'b0, dut_if.redirect_pending}, {31'b0, m_pend});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
